fx3_packet_writer: RTL and testbench
====================================

# fx3_packet_writer

Downstream consumer of the ADC sample FIFO in the fx3Clk domain. It waits until a full packet is buffered and the FX3 slave FIFO can accept it, then streams exactly one packet of 16-bit samples onto the FX3 GPIF bus. It generates the FIFO read request and the FX3 write strobe, compensating for the FIFO read-to-data pipeline latency. It also reports FX3 flow-control violations.

## Interface
- PACKET_WORDS, 8192, words per packet; power of two, 2..32768
- READ_LATENCY, 2, fx3Clk cycles from readData high to the matching word valid on dataIn (FIFO q register plus 10→16-bit conversion register)

Ports:
- fx3Clk  in  1  sole clock; all logic on its rising edge
- nReset  in  1  asynchronous, active-low reset
- collectData  in  1  capture enabled; gates packet starts only
- dataAvailable  in  1  FIFO holds ≥ PACKET_WORDS words
- dataIn  in  16  signed sample from the FIFO/conversion pipeline
- fx3Ready  in  1  FX3 slave-FIFO not-full flag (FLAGA), active high
- readData  out  1  FIFO read request
- fx3Data  out  16  registered GPIF data bus
- nSlwr  out  1  FX3 write strobe, active low
- nPktEnd  out  1  FX3 packet-end strobe, active low
- streamError  out  1  sticky: fx3Ready was low while words were being written
- packetCount  out  16  completed packets since reset, wraps

## Operation
- Reset values: readData=0, fx3Data=0, nSlwr=1, nPktEnd=1, streamError=0, packetCount=0. The state machine resets to IDLE.
- Reset asserted mid-packet aborts the packet immediately; no partial-packet recovery.
- States and transitions:
  - IDLE: go to READ when collectData & dataAvailable & fx3Ready are all high in the same cycle.
  - READ: readData=1 for exactly PACKET_WORDS consecutive cycles. A word counter of width log2(PACKET_WORDS) counts 0..PACKET_WORDS−1 and clears on entry. At terminal count, go to DRAIN.
  - DRAIN: readData=0. Wait until the write-strobe pipeline is empty, then go to DONE.
  - DONE: increment packetCount (16-bit wrap, 0xFFFF→0x0000); go to IDLE next cycle.
- A valid-pipeline shift register of depth READ_LATENCY+1 carries readData. Its final stage drives nSlwr (inverted).
- fx3Data <= dataIn every cycle. Strobe and data are therefore aligned on the same cycle.
- collectData falling mid-packet does not stop the packet; it completes. dataAvailable and fx3Ready are sampled only in IDLE.
- streamError sets on any cycle where nSlwr=0 and fx3Ready=0. It clears only when collectData is low or on reset, and set has priority over clear. Writing continues regardless.
- The FIFO is never read in IDLE, so an underflow cannot originate here.

## Timing
- Start condition true in cycle T0 → READ entered T0+1 → readData high T0+1..T0+PACKET_WORDS.
- nSlwr low, with valid fx3Data, for cycles T0+1+READ_LATENCY+1 .. T0+PACKET_WORDS+READ_LATENCY+1: exactly PACKET_WORDS contiguous cycles.
- Latency from start condition to first strobe is READ_LATENCY+2 cycles (4 with defaults).
- packetCount updates one cycle after the last nSlwr low.
- Earliest next start check is one cycle after DONE. Minimum inter-packet gap on nSlwr is READ_LATENCY+3 cycles.

## Configuration
- FX3_PKTEND_EN defined: nPktEnd is driven low on exactly the cycle carrying the final word of each packet, coincident with the last nSlwr low.
- FX3_PKTEND_EN undefined: nPktEnd is held at 1 permanently, and the FX3 commits buffers on its own auto-commit size.

## Test plan
- Reset, then idle with dataAvailable=0 for 100 cycles → readData=0, nSlwr=1, packetCount=0.
- collectData=dataAvailable=fx3Ready=1, dataIn as ramp modelled with 2-cycle latency → exactly 8192 readData cycles; nSlwr low 8192 contiguous cycles starting 4 cycles after start; fx3Data ramp unbroken; packetCount=1.
- FX3_PKTEND_EN defined → nPktEnd low only on word 8191; undefined → nPktEnd always 1.
- fx3Ready pulled low for one cycle mid-packet → streamError=1 and still 8192 strobes; drop collectData → streamError=0.
- collectData dropped at word 100 → packet completes (8192 strobes), no new start.
- nReset asserted at word 4000 → all outputs to reset values asynchronously; a fresh start after release gives a full 8192-word packet.

Source files
------------

// File: rtl/fx3_packet_writer.sv
// fx3_packet_writer: streams one buffered packet of 16-bit samples onto FX3 GPIF.
// Define FX3_PKTEND_EN to pulse nPktEnd low with the final word of each packet.
module fx3_packet_writer #(
  parameter int PACKET_WORDS = 8192,
  parameter int READ_LATENCY = 2
) (
  input  logic        fx3Clk,
  input  logic        nReset,
  input  logic        collectData,
  input  logic        dataAvailable,
  input  logic [15:0] dataIn,
  input  logic        fx3Ready,
  output logic        readData,
  output logic [15:0] fx3Data,
  output logic        nSlwr,
  output logic        nPktEnd,
  output logic        streamError,
  output logic [15:0] packetCount
);

  localparam int CW = (PACKET_WORDS > 1) ? $clog2(PACKET_WORDS) : 1;
  localparam int PD = READ_LATENCY + 1;
  localparam logic [CW-1:0] LAST = CW'(PACKET_WORDS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [PD-1:0] r_vpipe;
  logic [15:0]   r_data;
  logic [15:0]   r_pkts;
  logic          r_err;

  logic          w_start;
  logic          w_read;
  logic          w_last;
  logic          w_wr;
  logic          w_head_empty;
  logic [PD-1:0] w_head;

  assign w_start = collectData & dataAvailable & fx3Ready;
  assign w_read  = (r_state == S_READ);
  assign w_last  = w_read & (r_cnt == LAST);
  assign w_wr    = r_vpipe[PD-1];

  // DONE is entered as the final strobe leaves, so the count lands right after it
  always_comb begin
    w_head         = r_vpipe;
    w_head[PD-1]   = 1'b0;
  end
  assign w_head_empty = (w_head == '0);

  always_ff @(posedge fx3Clk or negedge nReset) begin
    if (!nReset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_pkts  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state <= S_READ;
            r_cnt   <= '0;
          end
        end
        S_READ: begin
          r_cnt <= r_cnt + CW'(1);
          if (w_last) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (w_head_empty) begin
            r_state <= S_DONE;
            r_pkts  <= r_pkts + 16'd1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge fx3Clk or negedge nReset) begin
    if (!nReset) begin
      r_vpipe <= '0;
      r_data  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_vpipe <= PD'({r_vpipe, w_read});
      r_data  <= dataIn;
      if (w_wr & ~fx3Ready)
        r_err <= 1'b1;
      else if (!collectData)
        r_err <= 1'b0;
    end
  end

`ifdef FX3_PKTEND_EN
  logic [PD-1:0] r_lpipe;

  always_ff @(posedge fx3Clk or negedge nReset) begin
    if (!nReset) r_lpipe <= '0;
    else         r_lpipe <= PD'({r_lpipe, w_last});
  end

  assign nPktEnd = ~r_lpipe[PD-1];
`else
  assign nPktEnd = 1'b1;
`endif

  assign readData    = w_read;
  assign fx3Data     = r_data;
  assign nSlwr       = ~w_wr;
  assign streamError = r_err;
  assign packetCount = r_pkts;

endmodule

// File: tb/tb_fx3_packet_writer.sv
// Bench for fx3_packet_writer: FIFO ramp model with 2-cycle latency and
// a scoreboard of expected GPIF words checked on every write strobe.
module tb_fx3_packet_writer;

  localparam int PW = 8192;
  localparam logic [15:0] JUNK = 16'hBAD0;
`ifdef FX3_PKTEND_EN
  localparam bit PKTEND = 1'b1;
`else
  localparam bit PKTEND = 1'b0;
`endif

  typedef struct packed {
    logic        last;
    logic [15:0] data;
  } exp_t;

  logic        fx3Clk = 1'b0;
  logic        nReset;
  logic        collectData;
  logic        dataAvailable;
  logic [15:0] dataIn;
  logic        fx3Ready;
  logic        readData;
  logic [15:0] fx3Data;
  logic        nSlwr;
  logic        nPktEnd;
  logic        streamError;
  logic [15:0] packetCount;

  int n_checks = 0;
  int n_fail   = 0;
  int n_rd     = 0;
  int rd_idx   = 0;
  logic [15:0] ramp = 16'd0;
  logic [15:0] s1 = JUNK;
  logic [15:0] s2 = JUNK;
  exp_t exp_q[$];

  fx3_packet_writer #(.PACKET_WORDS(PW), .READ_LATENCY(2)) dut (
    .fx3Clk        (fx3Clk),
    .nReset        (nReset),
    .collectData   (collectData),
    .dataAvailable (dataAvailable),
    .dataIn        (dataIn),
    .fx3Ready      (fx3Ready),
    .readData      (readData),
    .fx3Data       (fx3Data),
    .nSlwr         (nSlwr),
    .nPktEnd       (nPktEnd),
    .streamError   (streamError),
    .packetCount   (packetCount)
  );

  always #5 fx3Clk = ~fx3Clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // FIFO + conversion model and strobe-side scoreboard
  always @(negedge fx3Clk) begin
    exp_t e;
    logic pe;
    if (!nReset) begin
      exp_q.delete();
      rd_idx = 0;
      s1     = JUNK;
      s2     = JUNK;
      dataIn = JUNK;
    end else begin
      pe = 1'b0;
      if (!nSlwr) begin
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = '{last: 1'b0, data: JUNK};
        chk("fx3Data", 32'(fx3Data), 32'(e.data));
        pe = e.last;
      end
      chk("nPktEnd", 32'(nPktEnd), 32'(!(PKTEND && pe)));
      dataIn = s2;
      s2     = s1;
      if (readData) begin
        s1 = ramp;
        e.last = (rd_idx == PW - 1);
        e.data = ramp;
        exp_q.push_back(e);
        ramp   = ramp + 16'd1;
        n_rd++;
        rd_idx = (rd_idx == PW - 1) ? 0 : rd_idx + 1;
      end else begin
        s1 = JUNK;
      end
    end
  end

  task automatic run_pkt(input int rdy_at, input int col_at,
                         input bit keep_da, output int lat,
                         output int nstb);
    @(negedge fx3Clk);
    collectData   = 1'b1;
    fx3Ready      = 1'b1;
    dataAvailable = 1'b1;
    lat = 0;
    do begin
      @(negedge fx3Clk);
      lat++;
      if (lat == 1 && !keep_da) dataAvailable = 1'b0;
    end while (nSlwr && lat < 20);
    nstb = 0;
    while (!nSlwr && nstb < PW + 10) begin
      nstb++;
      fx3Ready = (nstb == rdy_at) ? 1'b0 : 1'b1;
      if (nstb == col_at) collectData = 1'b0;
      @(negedge fx3Clk);
    end
    fx3Ready = 1'b1;
  endtask

  initial begin
    int lat;
    int nstb;
    int base;
    int k;
    nReset        = 1'b0;
    collectData   = 1'b0;
    dataAvailable = 1'b0;
    fx3Ready      = 1'b0;
    dataIn        = JUNK;
    repeat (3) @(negedge fx3Clk);
    chk("rst_readData", 32'(readData), 0);
    chk("rst_fx3Data", 32'(fx3Data), 0);
    chk("rst_nSlwr", 32'(nSlwr), 1);
    chk("rst_nPktEnd", 32'(nPktEnd), 1);
    chk("rst_streamError", 32'(streamError), 0);
    chk("rst_packetCount", 32'(packetCount), 0);
    nReset      = 1'b1;
    collectData = 1'b1;
    fx3Ready    = 1'b1;
    repeat (100) @(negedge fx3Clk);
    chk("idle_reads", 32'(n_rd), 0);
    chk("idle_nSlwr", 32'(nSlwr), 1);
    chk("idle_packetCount", 32'(packetCount), 0);

    // plain packet
    base = n_rd;
    run_pkt(-1, -1, 1'b0, lat, nstb);
    chk("p1_latency", 32'(lat), 4);
    chk("p1_strobes", 32'(nstb), PW);
    chk("p1_packetCount", 32'(packetCount), 1);
    chk("p1_reads", 32'(n_rd - base), PW);
    chk("p1_sb_empty", 32'(exp_q.size()), 0);

    // one-cycle FX3 not-ready mid-packet
    base = n_rd;
    run_pkt(1000, -1, 1'b0, lat, nstb);
    chk("p2_strobes", 32'(nstb), PW);
    chk("p2_streamError", 32'(streamError), 1);
    chk("p2_packetCount", 32'(packetCount), 2);
    chk("p2_reads", 32'(n_rd - base), PW);
    @(negedge fx3Clk);
    chk("p2_err_sticky", 32'(streamError), 1);
    collectData = 1'b0;
    @(negedge fx3Clk);
    chk("p2_err_clear", 32'(streamError), 0);

    // collectData dropped mid-packet with data still available
    base = n_rd;
    run_pkt(-1, 100, 1'b1, lat, nstb);
    chk("p3_strobes", 32'(nstb), PW);
    repeat (20) @(negedge fx3Clk);
    chk("p3_no_restart", 32'(n_rd - base), PW);
    chk("p3_packetCount", 32'(packetCount), 3);
    chk("p3_sb_empty", 32'(exp_q.size()), 0);
    dataAvailable = 1'b0;

    // asynchronous reset mid-packet
    @(negedge fx3Clk);
    collectData   = 1'b1;
    dataAvailable = 1'b1;
    @(negedge fx3Clk);
    dataAvailable = 1'b0;
    base = n_rd;
    k = 0;
    while (n_rd - base < 4000 && k < 5000) begin
      @(negedge fx3Clk);
      k++;
    end
    chk("p4_reached", 32'(n_rd - base), 4000);
    #2 nReset = 1'b0;
    #1;
    chk("p4_readData", 32'(readData), 0);
    chk("p4_nSlwr", 32'(nSlwr), 1);
    chk("p4_fx3Data", 32'(fx3Data), 0);
    chk("p4_nPktEnd", 32'(nPktEnd), 1);
    chk("p4_streamError", 32'(streamError), 0);
    chk("p4_packetCount", 32'(packetCount), 0);
    repeat (3) @(negedge fx3Clk);
    nReset = 1'b1;
    repeat (2) @(negedge fx3Clk);
    base = n_rd;
    run_pkt(-1, -1, 1'b0, lat, nstb);
    chk("p5_latency", 32'(lat), 4);
    chk("p5_strobes", 32'(nstb), PW);
    chk("p5_packetCount", 32'(packetCount), 1);
    chk("p5_reads", 32'(n_rd - base), PW);
    chk("p5_sb_empty", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
